// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers.
// Bursts are capped at BURST_LEN words; FULL stalls the granted requester.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] DIN0,
  output logic              ACK0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] DIN1,
  output logic              ACK1,
  input  logic              FIFO_FULL,
  output logic              FIFO_WE_N,
  output logic [DATA_W-1:0] FIFO_DIN,
  output logic [1:0]        GNT_ID
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] bcnt_q, bcnt_d;

  logic in_g0, in_g1;
  logic gnt_req, oth_req;
  logic accept, burst_end;

  assign in_g0 = (state_q == G0);
  assign in_g1 = (state_q == G1);

  assign gnt_req = (in_g0 & REQ0) | (in_g1 & REQ1);
  assign oth_req = (in_g0 & REQ1) | (in_g1 & REQ0);

  assign accept    = gnt_req & ~FIFO_FULL;
  assign burst_end = accept & (bcnt_q == BURST_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      bcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (REQ0 && REQ1) begin
          state_d = last_q ? G0 : G1;
        end else if (REQ0) begin
          state_d = G0;
        end else if (REQ1) begin
          state_d = G1;
        end
      end
      G0, G1: begin
        // A dropped request wins over a same-cycle count end (no write).
        if (!gnt_req || burst_end) begin
          last_d = in_g1;
          bcnt_d = 8'd0;
          if (oth_req) begin
            state_d = in_g0 ? G1 : G0;
          end else if (burst_end) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ACK0      = ~RST & accept & in_g0;
  assign ACK1      = ~RST & accept & in_g1;
  assign FIFO_WE_N = RST | ~accept;
  assign FIFO_DIN  = in_g1 ? DIN1 : DIN0;
  assign GNT_ID    = RST ? 2'b00 : {in_g1, in_g0};

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences,
// and random traffic against an owner/word-count reference model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int BL = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ0 = 1'b0, REQ1 = 1'b0;
  logic [DW-1:0] DIN0 = '0, DIN1 = '0;
  logic          ACK0, ACK1;
  logic          FIFO_FULL = 1'b0;
  logic          FIFO_WE_N;
  logic [DW-1:0] FIFO_DIN;
  logic [1:0]    GNT_ID;

  fifo_wr_arbiter #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .DIN0(DIN0), .ACK0(ACK0),
    .REQ1(REQ1), .DIN1(DIN1), .ACK1(ACK1),
    .FIFO_FULL(FIFO_FULL), .FIFO_WE_N(FIFO_WE_N),
    .FIFO_DIN(FIFO_DIN), .GNT_ID(GNT_ID)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    bit rst, r0, r1, full;
    logic [7:0] d0, d1;
    bit we_n, a0, a1;
    logic [1:0] gnt;
    logic [7:0] din;
    bit cdin;
  } vec_t;

  // Reference model: who owns the port, words in this grant, last owner.
  int m_owner = -1;
  int m_words = 0;
  int m_last = 1;
  logic [7:0] p0 = 8'd0, p1 = 8'd0;
  int wr_src[$];
  logic [7:0] wr_data[$];
  int cyc = 0;
  int first_wr = -1, last_wr = -1;

  task automatic model_step(input bit rst, input bit r0, input bit r1,
                            input bit full);
    bit req[2];
    bit cnt_end;
    int o;
    req[0] = r0;
    req[1] = r1;
    if (rst) begin
      m_owner = -1; m_words = 0; m_last = 1;
    end else if (m_owner < 0) begin
      if (r0 && r1) m_owner = 1 - m_last;
      else if (r0) m_owner = 0;
      else if (r1) m_owner = 1;
    end else if (!req[m_owner] || !full) begin
      cnt_end = 1'b0;
      if (req[m_owner]) begin
        m_words++;
        cnt_end = (m_words == BL);
      end
      if (!req[m_owner] || cnt_end) begin
        o = m_owner;
        m_last = o;
        m_words = 0;
        if (req[1-o]) m_owner = 1 - o;
        else if (cnt_end) m_owner = o;
        else m_owner = -1;
      end
    end
  endtask

  task automatic run_cycle(input bit rst, input bit r0, input bit r1,
                           input bit full);
    bit acc;
    logic [1:0] eg;
    logic [7:0] ed;
    @(negedge CLK);
    RST = rst; REQ0 = r0; REQ1 = r1; FIFO_FULL = full;
    DIN0 = p0; DIN1 = p1;
    #1;
    acc = !rst && m_owner >= 0 && !full &&
          ((m_owner == 0) ? r0 : r1);
    eg = (rst || m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    ed = (m_owner == 1) ? p1 : p0;
    chk("we_n", FIFO_WE_N, !acc);
    chk("ack0", ACK0, acc && m_owner == 0);
    chk("ack1", ACK1, acc && m_owner == 1);
    chk("gnt", GNT_ID, eg);
    if (!rst) chk("din", FIFO_DIN, ed);
    if (acc) begin
      wr_src.push_back(m_owner);
      wr_data.push_back(ed);
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (m_owner == 0) p0++;
      else p1++;
    end
    model_step(rst, r0, r1, full);
    cyc++;
  endtask

  task automatic do_reset();
    run_cycle(1, 0, 0, 0);
    run_cycle(1, 0, 0, 0);
    wr_src.delete();
    wr_data.delete();
    p0 = 8'd0; p1 = 8'd0;
    first_wr = -1; last_wr = -1;
  endtask

  vec_t vt[14];

  initial begin
    int bad, k, base;
    vt[0]  = '{1,1,1,0, 8'h00,8'h00, 1,0,0, 2'b00, 8'h00, 0};
    vt[1]  = '{1,1,1,0, 8'h00,8'h00, 1,0,0, 2'b00, 8'h00, 0};
    vt[2]  = '{1,1,1,0, 8'h00,8'h00, 1,0,0, 2'b00, 8'h00, 0};
    vt[3]  = '{0,1,1,0, 8'h11,8'h22, 1,0,0, 2'b00, 8'h11, 1};
    vt[4]  = '{0,1,1,0, 8'hA0,8'h22, 0,1,0, 2'b01, 8'hA0, 1};
    vt[5]  = '{0,1,1,1, 8'hA1,8'h22, 1,0,0, 2'b01, 8'hA1, 1};
    vt[6]  = '{0,0,1,0, 8'hA1,8'h22, 1,0,0, 2'b01, 8'hA1, 1};
    vt[7]  = '{0,1,1,0, 8'hA1,8'hB1, 0,0,1, 2'b10, 8'hB1, 1};
    vt[8]  = '{0,0,1,0, 8'hA1,8'hB2, 0,0,1, 2'b10, 8'hB2, 1};
    vt[9]  = '{1,0,1,0, 8'hA1,8'hB3, 1,0,0, 2'b00, 8'h00, 0};
    vt[10] = '{0,1,1,0, 8'hC0,8'hB3, 1,0,0, 2'b00, 8'hC0, 1};
    vt[11] = '{0,1,1,0, 8'hC0,8'hB3, 0,1,0, 2'b01, 8'hC0, 1};
    vt[12] = '{0,0,0,0, 8'hC0,8'hB3, 1,0,0, 2'b01, 8'hC0, 1};
    vt[13] = '{0,0,0,0, 8'hC1,8'hB3, 1,0,0, 2'b00, 8'hC1, 1};
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      RST = vt[i].rst; REQ0 = vt[i].r0; REQ1 = vt[i].r1;
      FIFO_FULL = vt[i].full; DIN0 = vt[i].d0; DIN1 = vt[i].d1;
      #1;
      chk($sformatf("vec%0d_we_n", i), FIFO_WE_N, vt[i].we_n);
      chk($sformatf("vec%0d_ack0", i), ACK0, vt[i].a0);
      chk($sformatf("vec%0d_ack1", i), ACK1, vt[i].a1);
      chk($sformatf("vec%0d_gnt", i), GNT_ID, vt[i].gnt);
      if (vt[i].cdin) chk($sformatf("vec%0d_din", i), FIFO_DIN, vt[i].din);
    end

    // Single requester: one idle cycle, then unbroken in-order writes.
    do_reset();
    for (int i = 0; i < 40; i++) run_cycle(0, 1, 0, 0);
    chk("single_acks", wr_data.size(), 39);
    bad = 0;
    foreach (wr_data[i]) if (wr_data[i] != 8'(i)) bad++;
    chk("single_order", bad, 0);

    // Round-robin until a 1024-word FIFO fills.
    do_reset();
    for (int i = 0; i < 1100; i++)
      run_cycle(0, 1, 1, wr_data.size() >= 1024);
    chk("rr_total", wr_data.size(), 1024);
    bad = 0;
    foreach (wr_src[i]) if (wr_src[i] != (i / BL) % 2) bad++;
    chk("rr_alternate", bad, 0);
    chk("rr_no_bubble", last_wr - first_wr + 1, 1024);

    // FULL stall mid-burst after 7 words.
    do_reset();
    run_cycle(0, 1, 1, 0);
    for (int i = 0; i < 7; i++) run_cycle(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) run_cycle(0, 1, 1, 1);
    chk("stall_words", wr_data.size(), 7);
    for (int i = 0; i < 30; i++) run_cycle(0, 1, 1, 0);
    k = 7;
    while (k < wr_src.size() && wr_src[k] == 0) k++;
    chk("stall_resume", k - 7, 9);

    // Early drop in G1 with req0 waiting, then with nobody waiting.
    do_reset();
    run_cycle(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 1, 0);
    run_cycle(0, 1, 0, 0);
    run_cycle(0, 1, 0, 0);
    chk("drop_to_g0", GNT_ID, 2'b01);
    chk("drop_g0_ack", ACK0, 1'b1);
    do_reset();
    run_cycle(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 1, 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 0);
    chk("drop_to_idle", GNT_ID, 2'b00);

    // Reset in G1 with 10 words written.
    do_reset();
    run_cycle(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 1, 0);
    run_cycle(1, 1, 1, 0);
    chk("rst_mid_we_n", FIFO_WE_N, 1'b1);
    run_cycle(0, 1, 1, 0);
    chk("rst_mid_idle", GNT_ID, 2'b00);
    run_cycle(0, 1, 1, 0);
    chk("rst_mid_g0", GNT_ID, 2'b01);

    // Random traffic.
    do_reset();
    base = 0;
    for (int i = 0; i < 3000; i++) begin
      run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      if (wr_data.size() > 0) base = 1;
    end
    chk("rand_activity", base, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
